// File: rtl/fadd_issue.sv
// Issue controller for the non-pipelined fadd adder: operand FIFO, single-cycle req
// issue, fixed three-edge wait, and a valid/ready result register carrying a user tag.
module fadd_issue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_x,
    input  logic [31:0]              in_y,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     fa_req,
    output logic [31:0]              fa_x,
    output logic [31:0]              fa_y,
    input  logic [31:0]              fa_rslt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_rslt,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        CAP  = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [PW-1:0]      wr_ptr_r, rd_ptr_r;
    logic [PW:0]        count_r;
    logic [31:0]        mem_x_r   [DEPTH];
    logic [31:0]        mem_y_r   [DEPTH];
    logic [TAG_W-1:0]   mem_tag_r [DEPTH];
    logic [TAG_W-1:0]   tag_r;
    logic               fa_req_r;
    logic [31:0]        fa_x_r, fa_y_r;
    logic               out_valid_r;
    logic [31:0]        out_rslt_r;
    logic [TAG_W-1:0]   out_tag_r;
    logic               full_s, push_s, pop_s, capture_s, slot_free_s;

    assign full_s      = (count_r == CNT_FULL);
    assign push_s      = in_valid & ~full_s;
    assign slot_free_s = ~out_valid_r | out_ready;

    assign in_ready  = ~full_s;
    assign fa_req    = fa_req_r;
    assign fa_x      = fa_x_r;
    assign fa_y      = fa_y_r;
    assign out_valid = out_valid_r;
    assign out_rslt  = out_rslt_r;
    assign out_tag   = out_tag_r;
    assign count     = count_r;
    assign busy      = (state_r != IDLE) | (count_r != CNT_ZERO) | out_valid_r;

    // Next-state, pop and capture decode; a pop is always an issue to fadd
    always_comb begin
        state_s   = state_r;
        pop_s     = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (count_r != CNT_ZERO) begin
                    pop_s   = 1'b1;
                    state_s = S1;
                end else begin
                    state_s = IDLE;
                end
            end
            S1:  state_s = S2;
            S2:  state_s = S3;
            S3:  state_s = CAP;
            CAP: begin
                // Holding here keeps fadd's rslt stable until the result slot frees up
                if (slot_free_s) begin
                    capture_s = 1'b1;
                    if (count_r != CNT_ZERO) begin
                        pop_s   = 1'b1;
                        state_s = S1;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = CAP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (!push_s && pop_s) begin
                count_r <= count_r - CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // FIFO storage; contents are only read behind the occupancy count
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_x_r[wr_ptr_r]   <= in_x;
            mem_y_r[wr_ptr_r]   <= in_y;
            mem_tag_r[wr_ptr_r] <= in_tag;
        end
    end

    // Issue port to fadd and the tag of the operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fa_req_r <= 1'b0;
            fa_x_r   <= 32'h0000_0000;
            fa_y_r   <= 32'h0000_0000;
            tag_r    <= {TAG_W{1'b0}};
        end else begin
            fa_req_r <= pop_s;
            if (pop_s) begin
                fa_x_r <= mem_x_r[rd_ptr_r];
                fa_y_r <= mem_y_r[rd_ptr_r];
                tag_r  <= mem_tag_r[rd_ptr_r];
            end
        end
    end

    // Result register; a capture takes priority over a coincident transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_rslt_r  <= 32'h0000_0000;
            out_tag_r   <= {TAG_W{1'b0}};
        end else if (capture_s) begin
            out_valid_r <= 1'b1;
            out_rslt_r  <= fa_rslt;
            out_tag_r   <= tag_r;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_fadd_issue.sv
// Bench for fadd_issue: a timed behavioural fadd, a result scoreboard, and a directed
// sequence covering latency, burst, backpressure, reset and pointer wrap.
module tb_fadd_issue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready;
    logic [31:0]      in_x, in_y;
    logic [TAG_W-1:0] in_tag;
    logic             fa_req;
    logic [31:0]      fa_x, fa_y;
    logic [31:0]      fa_rslt = 32'h0;
    logic             out_valid, out_ready;
    logic [31:0]      out_rslt;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       count;
    logic             busy;

    fadd_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_tag(in_tag), .fa_req(fa_req), .fa_x(fa_x),
        .fa_y(fa_y), .fa_rslt(fa_rslt), .out_valid(out_valid), .out_ready(out_ready),
        .out_rslt(out_rslt), .out_tag(out_tag), .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [35:0] sb[$];
    int xfer_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, got, exp);
        end
    endtask

    // Single-precision add via real arithmetic (denormals flushed to zero)
    function automatic real sp2r(input logic [31:0] a);
        logic [63:0] d;
        if (a[30:23] == 8'h00)      d = {a[31], 63'd0};
        else if (a[30:23] == 8'hFF) d = {a[31], 11'h7FF, 52'd0};
        else                        d = {a[31], {3'b000, a[30:23]} + 11'd896, a[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        int e;
        logic [23:0] m;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 896;
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0) return {d[63], 31'd0};
        m = {1'b0, d[51:29]} + {23'd0, d[28]};
        if (m[23]) begin
            e = e + 1;
            m = 24'd0;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
        return r2sp(sp2r(a) + sp2r(b));
    endfunction

    // Behavioural fadd: latches on the req edge, adds next edge, writes rslt the edge after
    logic [1:0]  stage;
    logic [31:0] lx, ly;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage <= 2'd0;
        end else if (fa_req) begin
            lx <= fa_x;
            ly <= fa_y;
            stage <= 2'd1;
        end else if (stage == 2'd1) begin
            stage <= 2'd2;
        end else if (stage == 2'd2) begin
            fa_rslt <= f_add(lx, ly);
            stage <= 2'd0;
        end
    end

    // Protocol and scoreboard monitor
    logic        prev_ok = 1'b0, prev_req, prev_ov, prev_or;
    logic [31:0] prev_fx, prev_fy, prev_rslt;
    logic [3:0]  prev_tag;
    always @(negedge clk) begin
        logic [35:0] e;
        if (!reset) begin
            prev_ok = 1'b0;
        end else begin
            if (fa_req) check("req_while_fadd_busy", stage, 2'd0);
            if (prev_ok && fa_req) check("req_one_cycle", prev_req, 1'b0);
            if (prev_ok && !fa_req) begin
                check("fa_x_stable", fa_x, prev_fx);
                check("fa_y_stable", fa_y, prev_fy);
            end
            if (prev_ok && prev_ov && !prev_or) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_rslt", out_rslt, prev_rslt);
                check("stall_tag", out_tag, prev_tag);
            end
            if (out_valid && out_ready) begin
                check("result_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("result_rslt", out_rslt, e[35:4]);
                    check("result_tag", out_tag, e[3:0]);
                    xfer_cyc.push_back(cyc);
                end
            end
            prev_ok = 1'b1;
            prev_req = fa_req;
            prev_ov = out_valid;
            prev_or = out_ready;
            prev_fx = fa_x;
            prev_fy = fa_y;
            prev_rslt = out_rslt;
            prev_tag = out_tag;
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [3:0] t);
        int n = 0;
        in_x = x; in_y = y; in_tag = t; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready", in_ready, 1'b1);
        if (in_ready) begin
            @(posedge clk);
            sb.push_back({f_add(x, y), t});
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_ov();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_timeout", out_valid, 1'b1);
    endtask

    task automatic run_one(input logic [31:0] x, input logic [31:0] y, input logic [3:0] t,
                           input logic [31:0] exp);
        send(x, y, t);
        wait_ov();
        check("run_rslt", out_rslt, exp);
        check("run_tag", out_tag, t);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_busy", busy, 1'b0);
        check("drain_sb_empty", sb.size(), 0);
    endtask

    initial begin
        logic [31:0] x, y, exp1;
        reset = 1'b0; in_valid = 1'b0; in_x = 32'h0; in_y = 32'h0; in_tag = 4'h0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", count, 3'd0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_fa_req", fa_req, 1'b0);
        check("rst_fa_x", fa_x, 32'h0);
        check("rst_fa_y", fa_y, 32'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_rslt", out_rslt, 32'h0);
        check("rst_out_tag", out_tag, 4'h0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Single op latency: accepted at edge k
        send(32'h3F800000, 32'h40000000, 4'd5);
        @(negedge clk);
        check("single_count_k", count, 3'd1);
        check("single_req_k", fa_req, 1'b0);
        @(negedge clk);
        check("single_req_k1", fa_req, 1'b1);
        check("single_fa_x", fa_x, 32'h3F800000);
        check("single_fa_y", fa_y, 32'h40000000);
        check("single_count_k1", count, 3'd0);
        @(negedge clk);
        check("single_req_k2", fa_req, 1'b0);
        repeat (2) @(negedge clk);
        check("single_ov_k4", out_valid, 1'b0);
        @(negedge clk);
        check("single_ov_k5", out_valid, 1'b1);
        check("single_rslt", out_rslt, 32'h40400000);
        check("single_tag", out_tag, 4'd5);
        @(negedge clk);
        check("single_ov_k6", out_valid, 1'b0);
        check("single_busy_k6", busy, 1'b0);

        run_one(32'h3F800000, 32'hBF800000, 4'd1, 32'h00000000);
        run_one(32'h7F7FFFFF, 32'h7F7FFFFF, 4'd2, 32'h7F800000);
        drain();

        // Burst of six with the consumer always ready
        xfer_cyc.delete();
        for (int i = 0; i < 5; i++) send($urandom, $urandom, 4'(i));
        check("burst_count_full", count, 3'd4);
        check("burst_in_ready_low", in_ready, 1'b0);
        send($urandom, $urandom, 4'd5);
        drain();
        check("burst_results", xfer_cyc.size(), 6);
        for (int i = 1; i < xfer_cyc.size(); i++)
            check("burst_spacing", xfer_cyc[i] - xfer_cyc[i-1], 4);

        // Backpressure: two ops, consumer stalled for ten cycles
        out_ready = 1'b0;
        x = 32'h41200000; y = 32'h40A00000;
        exp1 = 32'h41700000;
        send(x, y, 4'd3);
        send(32'h42000000, 32'hC1000000, 4'd4);
        wait_ov();
        check("bp_first_rslt", out_rslt, exp1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_rslt", out_rslt, exp1);
            check("bp_no_req", fa_req, 1'b0);
        end
        drain();

        // Reset while the second op sits in S2 with three entries queued
        for (int i = 0; i < 5; i++) send($urandom, $urandom, 4'(8 + i));
        @(posedge clk);
        @(posedge clk); #1;
        check("pre_reset_count", count, 3'd3);
        reset = 1'b0;
        #1;
        check("midrst_count", count, 3'd0);
        check("midrst_fa_req", fa_req, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        run_one(32'h40400000, 32'h3F800000, 4'd9, 32'h40800000);
        drain();

        // Push and pop together in IDLE at count 1, then wrap the pointers
        send(32'h3F800000, 32'h3F800000, 4'd6);
        send(32'h40000000, 32'h40000000, 4'd7);
        check("pushpop_count", count, 3'd1);
        drain();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            out_ready = (i % 3 == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            send($urandom, $urandom, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
